// File: rtl/grad_mag.sv
// Gradient-magnitude stage: streams {Gx,Gy} from gradient memory and writes saturated L1 magnitude.
// Optional GRAD_MAG_THRESH_EN turns the output into a binary edge map using THRESH.
module grad_mag #(
   parameter int unsigned W_LOG2 = 8,
   parameter int unsigned H_LOG2 = 8,
   parameter int unsigned SHIFT  = 1,
   parameter int unsigned THRESH = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        grad_rd,
   output logic [15:0] grad_addr,
   input  logic [19:0] grad_di,
   output logic        mag_wr,
   output logic [15:0] mag_addr,
   output logic [7:0]  mag_do,
   output logic [7:0]  max_mag,
   output logic        done
);

   localparam int unsigned AW = W_LOG2 + H_LOG2;
   localparam logic [15:0] LastAddr = 16'((32'd1 << AW) - 32'd1);

   if (AW > 16 || THRESH > 256) begin : g_bad_param
      $error("grad_mag: W_LOG2+H_LOG2 must be <= 16 and THRESH <= 256");
   end

   typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        grad_rd_q, grad_rd_d;
   logic [15:0] grad_addr_q, grad_addr_d;
   logic        v1_q, v1_d;
   logic [15:0] a1_q, a1_d;
   logic        mag_wr_q, mag_wr_d;
   logic [15:0] mag_addr_q, mag_addr_d;
   logic [7:0]  mag_do_q, mag_do_d;
   logic [7:0]  max_q, max_d;
   logic        done_q, done_d;

   // Magnitude datapath, evaluated on the cycle grad_di is valid (v1_q).
   logic [10:0] gx_ext, gy_ext, ax, ay;
   logic [11:0] sum, shifted;
   logic [7:0]  sat, pix;
   logic        border;

   always_comb begin
      gx_ext  = {grad_di[19], grad_di[19:10]};
      gy_ext  = {grad_di[9], grad_di[9:0]};
      ax      = gx_ext[10] ? (~gx_ext + 11'd1) : gx_ext;
      ay      = gy_ext[10] ? (~gy_ext + 11'd1) : gy_ext;
      sum     = {1'b0, ax} + {1'b0, ay};
      shifted = sum >> SHIFT;
      sat     = (shifted > 12'd255) ? 8'hFF : shifted[7:0];
      border  = (&a1_q[W_LOG2-1:0]) | (&a1_q[AW-1:W_LOG2]);
`ifdef GRAD_MAG_THRESH_EN
      pix     = (32'(sat) >= THRESH) ? 8'hFF : 8'h00;
`else
      pix     = sat;
`endif
      if (border) begin
         pix = 8'h00;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      grad_rd_d   = 1'b0;
      grad_addr_d = grad_addr_q;
      v1_d        = grad_rd_q;
      a1_d        = grad_addr_q;
      mag_wr_d    = v1_q;
      mag_addr_d  = v1_q ? a1_q : mag_addr_q;
      mag_do_d    = v1_q ? pix : mag_do_q;
      max_d       = (v1_q && (pix > max_q)) ? pix : max_q;
      done_d      = done_q;

      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d = StRead;
               cnt_d   = 16'd0;
               max_d   = 8'd0;
               done_d  = 1'b0;
            end
         end
         StRead: begin
            grad_rd_d   = 1'b1;
            grad_addr_d = cnt_q;
            cnt_d       = cnt_q + 16'd1;
            if (cnt_q == LastAddr) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            // The final write is on the outputs now; done rises as it retires.
            if (mag_wr_q && (mag_addr_q == LastAddr)) begin
               state_d = StDone;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         cnt_q       <= 16'd0;
         grad_rd_q   <= 1'b0;
         grad_addr_q <= 16'd0;
         v1_q        <= 1'b0;
         a1_q        <= 16'd0;
         mag_wr_q    <= 1'b0;
         mag_addr_q  <= 16'd0;
         mag_do_q    <= 8'd0;
         max_q       <= 8'd0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         grad_rd_q   <= grad_rd_d;
         grad_addr_q <= grad_addr_d;
         v1_q        <= v1_d;
         a1_q        <= a1_d;
         mag_wr_q    <= mag_wr_d;
         mag_addr_q  <= mag_addr_d;
         mag_do_q    <= mag_do_d;
         max_q       <= max_d;
         done_q      <= done_d;
      end
   end

   assign grad_rd   = grad_rd_q;
   assign grad_addr = grad_addr_q;
   assign mag_wr    = mag_wr_q;
   assign mag_addr  = mag_addr_q;
   assign mag_do    = mag_do_q;
   assign max_mag   = max_q;
   assign done      = done_q;

endmodule

// File: tb/tb_grad_mag.sv
// Bench for grad_mag on a 4x4 image: two instances (SHIFT=0 and SHIFT=1) share one gradient memory.
module tb_grad_mag;

   localparam int N = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [19:0] mem [N];

   logic        grad_rd_w   [2];
   logic [15:0] grad_addr_w [2];
   logic        mag_wr_w    [2];
   logic [15:0] mag_addr_w  [2];
   logic [7:0]  mag_do_w    [2];
   logic [7:0]  max_mag_w   [2];
   logic        done_w      [2];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic [19:0] gdi;
      always @(posedge clk) if (grad_rd_w[g]) gdi <= mem[grad_addr_w[g][3:0]];
      grad_mag #(.W_LOG2(2), .H_LOG2(2), .SHIFT(g), .THRESH(64)) u_dut (
         .clk      (clk),
         .reset    (reset),
         .start    (start),
         .grad_rd  (grad_rd_w[g]),
         .grad_addr(grad_addr_w[g]),
         .grad_di  (gdi),
         .mag_wr   (mag_wr_w[g]),
         .mag_addr (mag_addr_w[g]),
         .mag_do   (mag_do_w[g]),
         .max_mag  (max_mag_w[g]),
         .done     (done_w[g])
      );
   end

   // Reference: per-pixel result straight from the arithmetic rules.
   function automatic int pix_exp(int sh, int a, logic [19:0] w);
      logic signed [9:0] sx, sy;
      int gx, gy, s;
      sx = w[19:10];
      sy = w[9:0];
      gx = int'(sx);
      gy = int'(sy);
      s = ((gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy)) >> sh;
      if (s > 255) s = 255;
`ifdef GRAD_MAG_THRESH_EN
      s = (s >= 64) ? 255 : 0;
`endif
      if ((a % 4) == 3 || (a / 4) == 3) s = 0;
      return s;
   endfunction

   function automatic logic [19:0] word(int gx, int gy);
      logic [9:0] hx, hy;
      hx = gx[9:0];
      hy = gy[9:0];
      return {hx, hy};
   endfunction

   // Frame timeline model: cyc = rising edges since the accepted start.
   int active = 0;
   int cyc = 0;
   int expv [2][N];

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         active <= 0;
         cyc    <= 0;
      end else if (start && (active == 0 || cyc >= N + 3)) begin
         active <= 1;
         cyc    <= 0;
         for (int d = 0; d < 2; d++)
            for (int a = 0; a < N; a++) expv[d][a] <= pix_exp(d, a, mem[a]);
      end else if (active != 0 && cyc < N + 3) begin
         cyc <= cyc + 1;
      end
   end

   function automatic int max_of(int d);
      int m;
      m = 0;
      for (int a = 0; a < N; a++) if (expv[d][a] > m) m = expv[d][a];
      return m;
   endfunction

   int n_vec = 0;
   int n_err = 0;
   int wr [2][N];
   int nw [2];
   int done_cyc [2];
   logic prev_done [2];

   function automatic void chk(string nm, int d, int act, int req);
      n_vec++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s dut%0d t=%0t: got %0d, expected %0d", nm, d, $time, act, req);
      end
   endfunction

   task automatic compare_loop();
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (!reset) begin
               chk("rst_grad_rd", d, int'(grad_rd_w[d]), 0);
               chk("rst_grad_addr", d, int'(grad_addr_w[d]), 0);
               chk("rst_mag_wr", d, int'(mag_wr_w[d]), 0);
               chk("rst_mag_addr", d, int'(mag_addr_w[d]), 0);
               chk("rst_mag_do", d, int'(mag_do_w[d]), 0);
               chk("rst_max_mag", d, int'(max_mag_w[d]), 0);
               chk("rst_done", d, int'(done_w[d]), 0);
            end else begin
               automatic bit e_rd = (active != 0) && cyc >= 1 && cyc <= N;
               automatic bit e_wr = (active != 0) && cyc >= 3 && cyc <= N + 2;
               automatic bit e_dn = (active != 0) && cyc >= N + 3;
               chk("grad_rd", d, int'(grad_rd_w[d]), int'(e_rd));
               if (e_rd) chk("grad_addr", d, int'(grad_addr_w[d]), cyc - 1);
               chk("mag_wr", d, int'(mag_wr_w[d]), int'(e_wr));
               if (e_wr) begin
                  chk("mag_addr", d, int'(mag_addr_w[d]), cyc - 3);
                  chk("mag_do", d, int'(mag_do_w[d]), expv[d][cyc - 3]);
               end
               chk("done", d, int'(done_w[d]), int'(e_dn));
               if (e_dn) chk("max_mag", d, int'(max_mag_w[d]), max_of(d));
            end
            if (active != 0 && cyc == 0) nw[d] = 0;
            if (mag_wr_w[d]) begin
               wr[d][mag_addr_w[d][3:0]] = int'(mag_do_w[d]);
               nw[d]++;
            end
            if (done_w[d] && !prev_done[d]) done_cyc[d] = cyc;
            prev_done[d] = done_w[d];
         end
      end
   endtask

   task automatic pulse_start();
      @(posedge clk);
      #2 start = 1'b1;
      @(posedge clk);
      #2 start = 1'b0;
   endtask

   task automatic wait_done();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (done_w[0]) seen = 1'b1;
      end
      chk("done_timeout", 0, int'(seen), 1);
      @(negedge clk);
   endtask

   task automatic run_frame();
      pulse_start();
      wait_done();
   endtask

   task automatic fill(logic [19:0] w);
      for (int a = 0; a < N; a++) mem[a] = w;
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         nw[d] = 0;
         done_cyc[d] = 0;
         prev_done[d] = 1'b0;
      end
      fill(20'h0);
      fork
         compare_loop();
      join_none
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      repeat (2) @(posedge clk);

`ifdef GRAD_MAG_THRESH_EN
      mem[0] = word(40, 30);
      mem[1] = word(30, 30);
      run_frame();
      chk("thr_mag0", 0, wr[0][0], 255);
      chk("thr_mag1", 0, wr[0][1], 0);
      chk("thr_max", 0, int'(max_mag_w[0]), 255);
      fill(20'h0);
`endif

      // Basic frame.
      mem[0] = word(3, -4);
      mem[1] = word(-10, 20);
      run_frame();
`ifndef GRAD_MAG_THRESH_EN
      chk("basic_mag0", 0, wr[0][0], 7);
      chk("basic_mag1", 0, wr[0][1], 30);
      chk("basic_mag1_sh1", 1, wr[1][1], 15);
      chk("basic_max", 0, int'(max_mag_w[0]), 30);
`endif
      chk("basic_nwrites", 0, nw[0], 16);
      chk("basic_done_cyc", 0, done_cyc[0], 19);

      // Saturation.
      fill(20'h0);
      mem[5] = word(-512, -512);
      run_frame();
`ifndef GRAD_MAG_THRESH_EN
      chk("sat_m512", 0, wr[0][5], 255);
      chk("sat_m512_sh1", 1, wr[1][5], 255);
`endif
      mem[5] = word(200, 100);
      run_frame();
`ifndef GRAD_MAG_THRESH_EN
      chk("sat_300", 0, wr[0][5], 255);
      chk("sat_300_sh1", 1, wr[1][5], 150);
`endif
      mem[5] = word(-255, -255);
      run_frame();
`ifndef GRAD_MAG_THRESH_EN
      chk("sat_510_sh1", 1, wr[1][5], 255);
`endif

      // Border pixels forced to zero.
      fill(word(5, 5));
      run_frame();
`ifndef GRAD_MAG_THRESH_EN
      chk("border_in0", 0, wr[0][0], 10);
      chk("border_in10", 0, wr[0][10], 10);
      chk("border_max", 0, int'(max_mag_w[0]), 10);
`endif
      chk("border_x3", 0, wr[0][3], 0);
      chk("border_y3", 0, wr[0][12], 0);
      chk("border_xy3", 0, wr[0][15], 0);

      // Start mid-frame is ignored; start in DONE repeats the frame.
      pulse_start();
      repeat (5) @(posedge clk);
      #2 start = 1'b1;
      @(posedge clk);
      #2 start = 1'b0;
      wait_done();
      chk("restart_nwrites", 0, nw[0], 16);
      chk("restart_done_cyc", 0, done_cyc[0], 19);
      run_frame();
      chk("repeat_nwrites", 0, nw[0], 16);
      chk("repeat_done_cyc", 0, done_cyc[0], 19);
      chk("repeat_border", 0, wr[0][7], 0);

      // Random frames.
      for (int f = 0; f < 20; f++) begin
         for (int a = 0; a < N; a++) mem[a] = 20'($urandom);
         if (f % 4 == 0) mem[$urandom_range(0, 10)] = word(-512, -512);
         run_frame();
         chk("rand_nwrites", 0, nw[0], 16);
      end

      // Reset mid-frame.
      for (int a = 0; a < N; a++) mem[a] = 20'($urandom);
      pulse_start();
      repeat (8) @(posedge clk);
      #2 reset = 1'b0;
      repeat (2) @(posedge clk);
      #2 reset = 1'b1;
      repeat (30) @(posedge clk);
      run_frame();
      chk("post_reset_nwrites", 1, nw[1], 16);

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/grad_mag.md
Name: grad_mag

Overview:
- Downstream consumer of the 256x256 gradient memory written by the image-gradient stage.
- Streams packed {Gx,Gy} words out of gradient memory and computes a saturated L1 magnitude per pixel.
- Writes one 8-bit magnitude per pixel into a magnitude memory and tracks the frame maximum.
- Feeds later edge / threshold stages; same memory-port style as the gradient stage.

Parameters:
W_LOG2, 8, log2 of image width (x = addr[W_LOG2-1:0])
H_LOG2, 8, log2 of image height (y = addr[W_LOG2+H_LOG2-1:W_LOG2]); W_LOG2+H_LOG2 <= 16
SHIFT, 1, right shift applied to |Gx|+|Gy| before saturation to 8 bits
THRESH, 64, edge threshold used only when GRAD_MAG_THRESH_EN is defined

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; begins a frame when idle
grad_rd  output  1  gradient memory read enable
grad_addr  output  16  gradient memory read address
grad_di  input  20  read data {Gx[19:10], Gy[9:0]}, both signed two's complement; valid the cycle after grad_addr/grad_rd
mag_wr  output  1  magnitude memory write enable
mag_addr  output  16  magnitude memory write address
mag_do  output  8  magnitude write data
max_mag  output  8  largest mag_do written this frame; valid while done=1
done  output  1  frame complete; level, held until next accepted start

Behaviour:
- reset low (async): state IDLE; grad_rd=0, grad_addr=0, mag_wr=0, mag_addr=0, mag_do=0, max_mag=0, done=0; pipeline valid bits cleared.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE: on start=1 -> READ; clear max_mag and done.
- READ: one read per cycle, no stalls. grad_rd=1; grad_addr = 0,1,...,N-1 with N = 2^(W_LOG2+H_LOG2). Cycle after grad_addr=N-1 is issued -> DRAIN with grad_rd=0.
- Pipeline, per address A:
  - cycle t: grad_addr=A, grad_rd=1.
  - cycle t+1: grad_di holds M[A]; block registers the result.
  - cycle t+2: mag_wr=1, mag_addr=A, mag_do=result.
  - Read-to-write latency is 2 cycles. Writes are in ascending address order, exactly one write per address, no gaps.
- Arithmetic:
  - ax = |Gx| and ay = |Gy|, each 10-bit unsigned; -512 maps to 512 (11-bit internally).
  - sum = ax+ay, 12-bit.
  - s = sum >> SHIFT.
  - mag_do = (s > 255) ? 255 : s[7:0].
- Border: if x == 2^W_LOG2-1 or y == 2^H_LOG2-1, mag_do=0 regardless of grad_di; the gradient stage leaves these entries undefined. The read is still issued so pipeline timing stays uniform.
- max_mag: updated in the same cycle as each write to max(max_mag, mag_do).
- DRAIN: waits until the write for address N-1 has completed, then -> DONE. done=1 from the cycle after the last mag_wr.
- Cycle count: start to done = N+3 cycles (start sampled at edge 0, done high after edge N+3).
- DONE: done=1, all enables 0; start -> IDLE handling (same cycle: clear done, enter READ next).
- start while in READ or DRAIN: ignored; no restart, no counter reset.
- reset mid-frame: immediate abort to reset values. No further writes; done stays 0.
- mag_wr=0 in all cycles other than the N write cycles; mag_addr/mag_do hold their last value when mag_wr=0.

Optional Feature:
- Macro: GRAD_MAG_THRESH_EN.
- Defined: mag_do = (saturated magnitude >= THRESH) ? 255 : 0, giving a binary edge map. Border rule still forces 0. max_mag then reports 255 if any edge was written, else 0.
- Undefined: plain saturated magnitude as above; THRESH unused.

Test Plan:
- W_LOG2=H_LOG2=2, SHIFT=0; memory M[0]={+3,-4}, M[1]={-10,+20}, rest 0; start -> mag writes addr 0..15 in order; mag[0]=7, mag[1]=30, others 0; done at cycle 19; max_mag=30.
- Saturation: SHIFT=0, M[5]={-512,-512} -> mag[5]=255; SHIFT=1, M[5]={+200,+100} -> 150; SHIFT=1, M[5]={-255,-255} -> 255.
- Border: 4x4, all entries {+5,+5}, SHIFT=0 -> addrs 3,7,11,12,13,14,15 = 0; all others = 10; max_mag=10.
- Start ignored / restart: second start pulse at cycle 6 of a frame -> exactly 16 writes, done at cycle 19; new start in DONE -> done drops next cycle, frame repeats identically.
- Reset mid-frame: reset low at cycle 8 -> same cycle all outputs 0; after release, no mag_wr and done=0 until a new start.
- With GRAD_MAG_THRESH_EN, THRESH=64, SHIFT=0: M[0]={+40,+30} -> 255; M[1]={+30,+30} -> 0; max_mag=255.
